// File: rtl/decode_stage_pipe.sv
// Registered MIPS ID stage: decodes one instruction per accepted beat into an
// ID/EX control bundle, with valid/ready handshakes and a one-bubble load-use stall.
module decode_stage_pipe #(
   parameter int ALU_W     = 5,
   parameter bit HAZARD_EN = 1'b1,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [10:0]      d_ctrl,
   output logic [ALU_W-1:0] d_alucode,
   output logic [4:0]       d_rs,
   output logic [4:0]       d_rt,
   output logic [4:0]       d_rd,
   output logic [4:0]       d_shamt,
   output logic [15:0]      d_imm,
   output logic [CNT_W-1:0] stall_cnt
);

   logic [5:0] op;
   logic [5:0] fn;
   logic [4:0] rs_f;
   logic [4:0] rt_f;

   assign op   = instr[31:26];
   assign fn   = instr[5:0];
   assign rs_f = instr[25:21];
   assign rt_f = instr[20:16];

   logic       br, jr, jmp, rdst, src_b, src_a;
   logic       m2r, mrd, mwr, rwr, ill;
   logic [4:0] alu;
   logic       use_rs, use_rt;

   always_comb begin
      br     = 1'b0;
      jr     = 1'b0;
      jmp    = 1'b0;
      rdst   = 1'b0;
      src_b  = 1'b0;
      src_a  = 1'b0;
      m2r    = 1'b0;
      mrd    = 1'b0;
      mwr    = 1'b0;
      rwr    = 1'b0;
      ill    = 1'b0;
      alu    = 5'd0;
      use_rs = 1'b1;
      use_rt = 1'b0;
      if (instr == 32'h0) begin
         use_rs = 1'b0;
      end else begin
         unique case (op)
            6'h00: begin
               use_rt = 1'b1;
               rdst   = 1'b1;
               rwr    = 1'b1;
               unique case (fn)
                  6'h20, 6'h21: alu = 5'd0;
                  6'h22, 6'h23: alu = 5'd5;
                  6'h24: alu = 5'd1;
                  6'h25: alu = 5'd3;
                  6'h26: alu = 5'd2;
                  6'h27: alu = 5'd4;
                  6'h2a: alu = 5'd19;
                  6'h2b: alu = 5'd20;
                  6'h04: alu = 5'd16;
                  6'h06: alu = 5'd17;
                  6'h07: alu = 5'd18;
                  6'h00: begin
                     alu = 5'd16; src_a = 1'b1; use_rs = 1'b0;
                  end
                  6'h02: begin
                     alu = 5'd17; src_a = 1'b1; use_rs = 1'b0;
                  end
                  6'h03: begin
                     alu = 5'd18; src_a = 1'b1; use_rs = 1'b0;
                  end
                  6'h08: begin
                     alu = 5'd9; jr = 1'b1; rdst = 1'b0; rwr = 1'b0;
                  end
                  default: begin
                     ill = 1'b1; rdst = 1'b0; rwr = 1'b0;
                  end
               endcase
            end
            6'h01: begin
               unique case (rt_f)
                  5'd1: begin alu = 5'd12; br = 1'b1; end
                  5'd0: begin alu = 5'd15; br = 1'b1; end
                  default: ill = 1'b1;
               endcase
            end
            6'h02: begin jmp = 1'b1; use_rs = 1'b0; end
            6'h04: begin alu = 5'd10; br = 1'b1; use_rt = 1'b1; end
            6'h05: begin alu = 5'd11; br = 1'b1; use_rt = 1'b1; end
            6'h06: begin
               if (rt_f == 5'd0) begin alu = 5'd14; br = 1'b1; end
               else ill = 1'b1;
            end
            6'h07: begin
               if (rt_f == 5'd0) begin alu = 5'd13; br = 1'b1; end
               else ill = 1'b1;
            end
            6'h08, 6'h09: begin src_b = 1'b1; rwr = 1'b1; end
            6'h0a: begin alu = 5'd19; src_b = 1'b1; rwr = 1'b1; end
            6'h0b: begin alu = 5'd20; src_b = 1'b1; rwr = 1'b1; end
            6'h0c: begin alu = 5'd6; src_b = 1'b1; rwr = 1'b1; end
            6'h0d: begin alu = 5'd8; src_b = 1'b1; rwr = 1'b1; end
            6'h0e: begin alu = 5'd7; src_b = 1'b1; rwr = 1'b1; end
            6'h23: begin
               src_b = 1'b1; m2r = 1'b1; mrd = 1'b1; rwr = 1'b1;
            end
            6'h2b: begin src_b = 1'b1; mwr = 1'b1; use_rt = 1'b1; end
            default: ill = 1'b1;
         endcase
      end
   end

   logic [10:0] ctrl_n;
   assign ctrl_n = {br, jr, jmp, rdst, src_b, src_a, m2r, mrd, mwr, rwr, ill};

   // held load whose destination is a source of the incoming instruction
   logic hazard;
   assign hazard = HAZARD_EN && out_valid && d_ctrl[3]
                   && (d_rt != 5'd0) && in_valid
                   && ((use_rs && rs_f == d_rt) || (use_rt && rt_f == d_rt));

   assign in_ready = !flush && !hazard && (!out_valid || out_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         d_ctrl    <= '0;
         d_alucode <= '0;
         d_rs      <= '0;
         d_rt      <= '0;
         d_rd      <= '0;
         d_shamt   <= '0;
         d_imm     <= '0;
         stall_cnt <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (in_valid && in_ready) begin
         out_valid <= 1'b1;
         d_ctrl    <= ctrl_n;
         d_alucode <= ALU_W'(alu);
         d_rs      <= rs_f;
         d_rt      <= rt_f;
         d_rd      <= instr[15:11];
         d_shamt   <= instr[10:6];
         d_imm     <= instr[15:0];
      end else if (out_ready) begin
         out_valid <= 1'b0;
         if (hazard && stall_cnt != '1)
            stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe: decode values, handshakes,
// load-use bubble, hold, flush and asynchronous reset.
module tb_decode_stage_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] instr;

   logic        in_ready, out_valid;
   logic [10:0] d_ctrl;
   logic [4:0]  d_alucode, d_rs, d_rt, d_rd, d_shamt;
   logic [15:0] d_imm, stall_cnt;

   logic        in_ready2, out_valid2;
   logic [10:0] d_ctrl2;
   logic [4:0]  d_alucode2, d_rs2, d_rt2, d_rd2, d_shamt2;
   logic [15:0] d_imm2, stall_cnt2;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   decode_stage_pipe #(.ALU_W(5), .HAZARD_EN(1'b1), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
      .out_valid(out_valid), .out_ready(out_ready),
      .d_ctrl(d_ctrl), .d_alucode(d_alucode),
      .d_rs(d_rs), .d_rt(d_rt), .d_rd(d_rd), .d_shamt(d_shamt),
      .d_imm(d_imm), .stall_cnt(stall_cnt)
   );

   decode_stage_pipe #(.ALU_W(5), .HAZARD_EN(1'b0), .CNT_W(16)) dut2 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready2), .instr(instr),
      .out_valid(out_valid2), .out_ready(out_ready),
      .d_ctrl(d_ctrl2), .d_alucode(d_alucode2),
      .d_rs(d_rs2), .d_rt(d_rt2), .d_rd(d_rd2), .d_shamt(d_shamt2),
      .d_imm(d_imm2), .stall_cnt(stall_cnt2)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [31:0] w);
      instr     = w;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid  = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
      out_ready = 1'b0; instr = 32'h0;
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_ctrl", d_ctrl, 0);
      chk("rst_alu", d_alucode, 0);
      chk("rst_cnt", stall_cnt, 0);
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // ADD $3,$1,$2
      instr = 32'h00221820; in_valid = 1'b1; out_ready = 1'b1;
      #1 chk("add_inrdy", in_ready, 1);
      tick();
      in_valid = 1'b0;
      chk("add_valid", out_valid, 1);
      chk("add_alu", d_alucode, 0);
      chk("add_ctrl", d_ctrl, 11'h082);
      chk("add_rd", d_rd, 3);
      tick();
      chk("add_drain", out_valid, 0);

      // LW $2,0($1) then ADD reading $2
      beat(32'h8C220000);
      chk("lw_ctrl", d_ctrl, 11'h05A);
      chk("lw_rt", d_rt, 2);
      instr = 32'h00221820; in_valid = 1'b1;
      #1;
      chk("hz_inrdy", in_ready, 0);
      chk("hz_off_inrdy", in_ready2, 1);
      tick();
      chk("bubble_valid", out_valid, 0);
      chk("bubble_cnt", stall_cnt, 1);
      chk("bubble_inrdy", in_ready, 1);
      tick();
      in_valid = 1'b0;
      chk("post_valid", out_valid, 1);
      chk("post_ctrl", d_ctrl, 11'h082);
      chk("post_rd", d_rd, 3);
      tick();

      // LW $0 then ADD reading $0: no stall
      beat(32'h8C200000);
      instr = 32'h00001820; in_valid = 1'b1;
      #1 chk("lw0_inrdy", in_ready, 1);
      tick();
      in_valid = 1'b0;
      chk("lw0_valid", out_valid, 1);
      chk("lw0_ctrl", d_ctrl, 11'h082);
      chk("lw0_cnt", stall_cnt, 1);
      tick();

      // NOP
      beat(32'h00000000);
      chk("nop_valid", out_valid, 1);
      chk("nop_ctrl", d_ctrl, 0);
      chk("nop_alu", d_alucode, 0);
      tick();

      // ORI held with out_ready low
      instr = 32'h34220005; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      instr = 32'h00221820;
      for (int i = 0; i < 3; i++) begin
         #1 chk("hold_inrdy", in_ready, 0);
         tick();
         chk("hold_valid", out_valid, 1);
         chk("hold_alu", d_alucode, 8);
         chk("hold_ctrl", d_ctrl, 11'h042);
         chk("hold_imm", d_imm, 5);
      end

      // flush while holding with a pending beat
      flush = 1'b1;
      #1 chk("fl_inrdy", in_ready, 0);
      tick();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      chk("fl_valid", out_valid, 0);
      chk("fl_noload", d_alucode, 8);
      chk("fl_cnt", stall_cnt, 1);

      beat(32'hFC000000);
      chk("ill_valid", out_valid, 1);
      chk("ill_ctrl", d_ctrl, 11'h001);
      chk("ill_alu", d_alucode, 0);

      beat(32'h04210004);
      chk("bgez_alu", d_alucode, 12);
      chk("bgez_ctrl", d_ctrl, 11'h400);
      beat(32'h04200004);
      chk("bltz_alu", d_alucode, 15);
      chk("bltz_ctrl", d_ctrl, 11'h400);
      beat(32'h03E00008);
      chk("jr_alu", d_alucode, 9);
      chk("jr_ctrl", d_ctrl, 11'h200);
      tick();

      // reset asserted mid-stall
      beat(32'h8C220000);
      instr = 32'h00221820; in_valid = 1'b1; out_ready = 1'b0;
      #1 chk("ms_inrdy", in_ready, 0);
      tick();
      chk("ms_held", d_ctrl, 11'h05A);
      rst_n = 1'b0;
      #1;
      chk("ar_valid", out_valid, 0);
      chk("ar_ctrl", d_ctrl, 0);
      chk("ar_rt", d_rt, 0);
      chk("ar_imm", d_imm, 0);
      chk("ar_cnt", stall_cnt, 0);
      in_valid = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
